q_state_passthrough_responder: RTL

- Responder end of the dut_valid/dut_ready start/done handshake used by the quantum emulator top.
- On each accepted job, reads the header and state vector from q_state_input SRAM and writes the unmodified vector to q_state_output SRAM (identity circuit).
- Serves as the bring-up DUT for the bench and SRAM-load/compare infrastructure, and as the copy-out stage for zero-gate jobs.

---
 rtl/q_state_passthrough_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/q_state_passthrough_responder.sv
// Identity-circuit responder: on each accepted job it reads the header and the
// 2^Q amplitudes from the input state SRAM and copies them bit-exact to the
// output state SRAM. It then reports completion through dut_ready.
module q_state_passthrough_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int MAX_Q  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic              q_state_input_sram_write_enable,
    output logic [ADDR_W-1:0] q_state_input_sram_write_address,
    output logic [DATA_W-1:0] q_state_input_sram_write_data,
    output logic [ADDR_W-1:0] q_state_input_sram_read_address,
    input  logic [DATA_W-1:0] q_state_input_sram_read_data,
    output logic              q_state_output_sram_write_enable,
    output logic [ADDR_W-1:0] q_state_output_sram_write_address,
    output logic [DATA_W-1:0] q_state_output_sram_write_data,
    output logic [ADDR_W-1:0] q_state_output_sram_read_address,
    input  logic [DATA_W-1:0] q_state_output_sram_read_data,
    output logic              err
);

    // The header carries Q in its upper half. M in the lower half is ignored.
    localparam int HALF   = DATA_W / 2;
    // Bits needed to express any accepted Q (0..MAX_Q) as a shift amount.
    localparam int QSEL_W = (MAX_Q < 2) ? 1 : $clog2(MAX_Q + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LEN   = 3'd2,
        COPY  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [HALF-1:0]   q_field;
    logic              q_bad;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n_last;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;

    // The whole upper half is compared, so any stray upper bit also rejects.
    assign q_field = q_state_input_sram_read_data[DATA_W-1:HALF];
    assign q_bad   = (q_field > HALF'(MAX_Q));

    // The input SRAM is never written, and the output SRAM is never read.
    assign q_state_input_sram_write_enable  = 1'b0;
    assign q_state_input_sram_write_address = '0;
    assign q_state_input_sram_write_data    = '0;
    assign q_state_output_sram_read_address = '0;

    logic unused_out_read;
    assign unused_out_read = ^q_state_output_sram_read_data;

    // Each amplitude is written one cycle after its read address was issued.
    // The data comes straight from the SRAM read port and is forced to zero
    // when no write is in progress.
    assign q_state_output_sram_write_enable  = wr_en_p1;
    assign q_state_output_sram_write_address = wr_addr_p1;
    assign q_state_output_sram_write_data    = wr_en_p1 ? q_state_input_sram_read_data : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake and read-address generation
    always_comb begin
        state_next                      = state;
        dut_ready                       = 1'b0;
        accept                          = 1'b0;
        q_state_input_sram_read_address = '0;
        case (state)
            IDLE: begin
                dut_ready = 1'b1;
                if (dut_valid) begin
                    accept     = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                state_next = LEN;
            end
            LEN: begin
                state_next = q_bad ? DONE : COPY;
            end
            COPY: begin
                q_state_input_sram_read_address = idx;
                if (idx == n_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                // ready is already high here, so a valid seen now is a new job
                dut_ready = 1'b1;
                if (dut_valid) begin
                    accept     = 1'b1;
                    state_next = HDR;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job length, copy index, sticky error flag and the one-cycle write pipe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            n_last     <= '0;
            err        <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            if (accept) begin
                err <= 1'b0;
            end else if (state == LEN && q_bad) begin
                err <= 1'b1;
            end

            if (state == LEN) begin
                idx    <= ADDR_W'(1);
                n_last <= ADDR_W'(1) << q_field[QSEL_W-1:0];
            end else if (state == COPY) begin
                idx <= idx + ADDR_W'(1);
            end

            // stage boundary: issued read address -> output write one cycle later
            wr_en_p1   <= (state == COPY);
            wr_addr_p1 <= (state == COPY) ? (idx - ADDR_W'(1)) : '0;
        end
    end

endmodule
